fpga_status_panel: RTL

- Parametrised board-level front panel that sits between the FPGA board pins (buttons, switches, LEDs) and the pipelined RISC-V `top` core.
- Successor to the fixed "all LEDs = done" wrapper logic.
- Functions:
  - Synchronises and debounces buttons.
  - Generates a synchronised core reset from a switch.
  - Latches the core's done flag and counts run cycles.
  - Multiplexes done, heartbeat, status-word or cycle-count nibbles onto N LEDs under switch control.

---
 rtl/fpga_status_panel.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fpga_status_panel.sv
// rtl/fpga_status_panel.sv - board front panel: button debounce, core reset sync, run counter, LED pages
// Optional LED dimming is enabled with `define FPGA_STATUS_PANEL_PWM_EN.
module fpga_status_panel #(
    parameter int NUM_LEDS        = 4,
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HEARTBEAT_BITS  = 24,
    parameter int STATUS_W        = 32,
    parameter int CNT_W           = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn,
    input  logic [3:0]          sw,
    input  logic                core_done,
    input  logic [STATUS_W-1:0] core_status,
    output logic                core_reset_n,
    output logic [NUM_BTNS-1:0] btn_pulse,
    output logic [NUM_LEDS-1:0] led
);
    localparam int PAD_W = (STATUS_W > CNT_W) ? STATUS_W : CNT_W;
    localparam int PAGES = PAD_W / NUM_LEDS;
    localparam int PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HB_W  = (NUM_LEDS > 3) ? NUM_LEDS : 3;
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PG_W-1:0] PG_LAST = PG_W'(PAGES - 1);

    logic [NUM_BTNS-1:0]            btn_s1_q, btn_s2_q, btn_acc_q, btn_acc_d;
    logic [NUM_BTNS-1:0]            btn_pulse_q, btn_pulse_d;
    logic [NUM_BTNS-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]                     sw_s1_q, sw_s2_q;
    logic                           rst_s1_q, rst_s1_d, rst_s2_q, rst_s2_d;
    logic                           done_sticky_q, done_sticky_d, sticky_clr;
    logic [CNT_W-1:0]               cycle_cnt_q, cycle_cnt_d;
    logic [PG_W-1:0]                page_q, page_d;
    logic [HEARTBEAT_BITS-1:0]      hb_q, hb_d;
    logic [NUM_LEDS-1:0]            led_q, led_d;
    logic [PAD_W-1:0]               status_pad, cnt_pad;
    logic [HB_W-1:0]                hb_pad;

    always_comb begin
        btn_acc_d   = btn_acc_q;
        btn_pulse_d = '0;
        db_cnt_d    = db_cnt_q;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (btn_s2_q[i] == btn_acc_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
                db_cnt_d[i]    = '0;
                btn_acc_d[i]   = btn_s2_q[i];
                btn_pulse_d[i] = btn_s2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end

        // A low synchronised run switch clears both reset stages at once.
        rst_s1_d = sw_s2_q[0];
        rst_s2_d = rst_s1_q & sw_s2_q[0];

        sticky_clr    = btn_pulse_q[0] | ~rst_s2_q;
        done_sticky_d = sticky_clr ? 1'b0 : (done_sticky_q | core_done);
        cycle_cnt_d   = cycle_cnt_q;
        if (sticky_clr)
            cycle_cnt_d = '0;
        else if (!done_sticky_q && cycle_cnt_q != '1)
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);

        page_d = page_q;
        if (btn_pulse_q[1]) begin
            if (sw_s2_q[3])
                page_d = (page_q == '0) ? PG_LAST : page_q - PG_W'(1);
            else
                page_d = (page_q == PG_LAST) ? '0 : page_q + PG_W'(1);
        end

        hb_d = hb_q + HEARTBEAT_BITS'(1);

        status_pad                 = '0;
        status_pad[STATUS_W-1:0]   = core_status;
        cnt_pad                    = '0;
        cnt_pad[CNT_W-1:0]         = cycle_cnt_q;
        hb_pad                     = '0;
        hb_pad[2:0]                = {rst_s2_q, done_sticky_q, hb_q[HEARTBEAT_BITS-1]};

        led_d = '0;
        case (sw_s2_q[2:1])
            2'b00: led_d = {NUM_LEDS{done_sticky_q}};
            2'b01: led_d = hb_pad[NUM_LEDS-1:0];
            default: begin
                for (int p = 0; p < PAGES; p++) begin
                    if (page_q == PG_W'(p))
                        led_d = sw_s2_q[1] ? cnt_pad[p*NUM_LEDS +: NUM_LEDS]
                                           : status_pad[p*NUM_LEDS +: NUM_LEDS];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            btn_acc_q     <= '0;
            btn_pulse_q   <= '0;
            db_cnt_q      <= '0;
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            rst_s1_q      <= 1'b0;
            rst_s2_q      <= 1'b0;
            done_sticky_q <= 1'b0;
            cycle_cnt_q   <= '0;
            page_q        <= '0;
            hb_q          <= '0;
            led_q         <= '0;
        end else begin
            btn_s1_q      <= btn;
            btn_s2_q      <= btn_s1_q;
            btn_acc_q     <= btn_acc_d;
            btn_pulse_q   <= btn_pulse_d;
            db_cnt_q      <= db_cnt_d;
            sw_s1_q       <= sw;
            sw_s2_q       <= sw_s1_q;
            rst_s1_q      <= rst_s1_d;
            rst_s2_q      <= rst_s2_d;
            done_sticky_q <= done_sticky_d;
            cycle_cnt_q   <= cycle_cnt_d;
            page_q        <= page_d;
            hb_q          <= hb_d;
            led_q         <= led_d;
        end
    end

    assign core_reset_n = rst_s2_q;
    assign btn_pulse    = btn_pulse_q;

`ifdef FPGA_STATUS_PANEL_PWM_EN
    localparam int DUTY_BTN = (NUM_BTNS > 2) ? 2 : NUM_BTNS - 1;

    logic [7:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
    logic       duty_step;

    always_comb begin
        duty_step = btn_pulse_q[DUTY_BTN] & (NUM_BTNS > 2);
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        duty_d    = duty_step ? duty_q + 8'h20 : duty_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q <= '0;
            duty_q    <= 8'h20;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
        end
    end

    assign led = led_q & {NUM_LEDS{pwm_cnt_q < duty_q}};
`else
    assign led = led_q;
`endif

endmodule
